ram_line_server: RTL and testbench
==================================

Name: ram_line_server

Overview:
Backing-memory stage directly downstream of the cache's byte-wide RAM port. It accepts one line request at a time (line address, read/write flag), then transfers a full 16-byte line as 16 single-byte beats, each marked by a one-cycle ram_ack. It holds the byte array that backs the cache, and adds a programmable access latency so the cache's refill and writeback paths are exercised under realistic timing. A side-band debug read port lets the bench inspect memory contents without using the handshake.

Parameters:
LINE_ADDR_WIDTH, 12, line address width (tag+index)
BYTE_WIDTH, 8, data beat width
LINE_BYTES, 16, beats per line (power of two)
LATENCY, 2, idle cycles between request acceptance and first beat (0..15)

Ports:
ram_clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ram_addr  in  LINE_ADDR_WIDTH  line address, valid with ram_avalid
ram_avalid  in  1  request valid / held for whole burst
ram_rnw  in  1  1=read line, 0=write line; sampled at acceptance
ram_wdata  in  BYTE_WIDTH  write byte, sampled when ram_ack=1
ram_rdata  out  BYTE_WIDTH  read byte, valid when ram_ack=1
ram_ack  out  1  one-cycle beat strobe
busy  out  1  high from acceptance until return to IDLE
dbg_addr  in  LINE_ADDR_WIDTH+4  byte address for backdoor read
dbg_rdata  out  BYTE_WIDTH  combinational mem[dbg_addr]

Behaviour:
- Memory: 2^LINE_ADDR_WIDTH * LINE_BYTES bytes; byte address = {line_addr, beat[3:0]}. Contents are not affected by reset and are X until written or preloaded.
- Reset (rst=0, async): state=IDLE, ram_ack=0, ram_rdata=0, busy=0, counters=0. Reset during a burst aborts it; bytes already written stay written.
- States: IDLE, LAT, BURST, HOLD.
- IDLE: a rising edge with ram_avalid=1 latches ram_addr and ram_rnw, then goes to LAT (LATENCY>0) or BURST (LATENCY=0). busy goes to 1 on that same edge.
- LAT: down-counter loaded with LATENCY-1; moves to BURST when it reaches 0. Exactly LATENCY cycles elapse with ram_ack=0.
- BURST: ram_ack=1 on every cycle for beats 0..LINE_BYTES-1, back-to-back.
  - Read: ram_rdata = mem[{addr,beat}] registered, valid in the same cycle as ram_ack.
  - Write: on an edge where ram_ack=1, mem[{addr,beat}] <= ram_wdata.
  - After the last beat, go to HOLD.
- HOLD: busy=0, ram_ack=0. Wait for ram_avalid=0, then IDLE. A still-high ram_avalid never re-triggers a request.
- Byte k of the line is bits [8k+7:8k]. Beat 0 is first.
- Timing: the first beat is asserted LATENCY+1 cycles after the accepting edge. A full transaction lasts LATENCY+16 cycles with busy=1.
- Abort: if ram_avalid=0 is sampled in LAT or BURST, go to IDLE on the next edge with no further acks. Already-written bytes remain.
- ram_addr and ram_rnw changes after acceptance are ignored.
- ram_rdata holds its last value outside read beats. The bench checks it only when ram_ack=1.
- The beat counter is LINE_BYTES-wide modulo and clears on entering BURST. The address never wraps into the next line.

Test Plan:
- LATENCY=2, preload line 0x3A5 bytes 0x00..0x0F, read request -> ram_ack first high on the 3rd cycle after acceptance, 16 consecutive acks with ram_rdata=0x00..0x0F, busy low after the 16th.
- Write line 0x012, ram_wdata=0xF0+beat -> dbg_addr 0x0120..0x012F read 0xF0..0xFF. Line 0x011 and line 0x013 bytes unchanged.
- ram_avalid held high 5 cycles after the last beat -> no second burst; dropping it then raising with line 0x7FF -> new burst accepted, bytes from 0x7FF0..0x7FFF.
- Write burst, ram_avalid dropped after beat 5 -> beats 0..5 written, bytes 6..15 keep old values, no ack after the drop, returns to IDLE next edge.
- rst pulsed low for one cycle during beat 9 of a read -> ram_ack=0 and busy=0 immediately (async); the next request completes normally with correct data.
- LATENCY=0 build -> first ack on the cycle after acceptance; ram_addr changed mid-burst has no effect on the addresses read.

Source files
------------

// File: rtl/ram_line_server.sv
// ram_line_server: byte-wide backing memory behind the cache RAM port.
// A request names one line. After LATENCY idle cycles the line moves as
// LINE_BYTES single-byte beats, and a one-cycle ram_ack marks each beat.
// dbg_addr/dbg_rdata is an asynchronous side-band read port that shows the
// memory contents without using the handshake.
module ram_line_server #(
  parameter int LINE_ADDR_WIDTH = 12,
  parameter int BYTE_WIDTH      = 8,
  parameter int LINE_BYTES      = 16,
  parameter int LATENCY         = 2
) (
  input  logic                       ram_clk,
  input  logic                       rst,
  input  logic [LINE_ADDR_WIDTH-1:0] ram_addr,
  input  logic                       ram_avalid,
  input  logic                       ram_rnw,
  input  logic [BYTE_WIDTH-1:0]      ram_wdata,
  output logic [BYTE_WIDTH-1:0]      ram_rdata,
  output logic                       ram_ack,
  output logic                       busy,
  input  logic [LINE_ADDR_WIDTH+3:0] dbg_addr,
  output logic [BYTE_WIDTH-1:0]      dbg_rdata
);

  localparam int BEAT_W    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int MEM_AW    = LINE_ADDR_WIDTH + BEAT_W;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int LAT_W     = 4;
  localparam bit NO_LAT    = (LATENCY == 0);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = NO_LAT ? '0 : LAT_W'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAT   = 2'd1,
    BURST = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                     state_reg;
  logic [LINE_ADDR_WIDTH-1:0] addr_reg;
  logic                       rnw_reg;
  logic [BEAT_W-1:0]          beat_reg;
  logic [LAT_W-1:0]           lat_cnt_reg;

  // Reset does not touch the memory array. It holds X until something writes it.
  logic [BYTE_WIDTH-1:0] mem [MEM_DEPTH];

  logic [LINE_ADDR_WIDTH-1:0] rd_line;
  logic [BEAT_W-1:0]          rd_beat;
  logic [MEM_AW-1:0]          rd_addr;
  logic                       mem_we;
  logic [MEM_AW-1:0]          wr_addr;

  // Address of the byte that the next edge places on ram_rdata.
  // In IDLE it comes from the live request. The first beat that leaves LAT
  // reads beat 0. Inside a burst it reads the beat after the current one.
  always_comb begin
    rd_line = addr_reg;
    rd_beat = beat_reg + 1'b1;
    if (state_reg == IDLE) begin
      rd_line = ram_addr;
      rd_beat = '0;
    end else if (state_reg == LAT) begin
      rd_beat = '0;
    end
  end

  assign rd_addr = {rd_line, rd_beat};

  // Every acked write beat stores its byte. That includes the beat on which
  // ram_avalid drops, so an aborted write keeps everything up to that beat.
  assign mem_we  = (state_reg == BURST) && !rnw_reg;
  assign wr_addr = {addr_reg, beat_reg};

  // Memory write port. It has no reset, so the array can map onto block RAM.
  always_ff @(posedge ram_clk) begin
    if (mem_we) begin
      mem[wr_addr] <= ram_wdata;
    end
  end

  // Asynchronous side-band read that lets a bench inspect the contents.
  assign dbg_rdata = mem[dbg_addr[MEM_AW-1:0]];

  // Request FSM. It drives the registered ack, read data and busy outputs.
  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      rnw_reg     <= 1'b1;
      beat_reg    <= '0;
      lat_cnt_reg <= '0;
      ram_ack     <= 1'b0;
      ram_rdata   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ram_avalid) begin
            addr_reg    <= ram_addr;
            rnw_reg     <= ram_rnw;
            busy        <= 1'b1;
            beat_reg    <= '0;
            lat_cnt_reg <= LAT_LOAD;
            if (NO_LAT) begin
              // With no latency, beat 0 appears on the cycle after acceptance.
              state_reg <= BURST;
              ram_ack   <= 1'b1;
              if (ram_rnw) begin
                ram_rdata <= mem[rd_addr];
              end
            end else begin
              state_reg <= LAT;
            end
          end
        end

        LAT: begin
          if (!ram_avalid) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (lat_cnt_reg == '0) begin
            state_reg <= BURST;
            ram_ack   <= 1'b1;
            beat_reg  <= '0;
            if (rnw_reg) begin
              ram_rdata <= mem[rd_addr];
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end

        BURST: begin
          if (!ram_avalid) begin
            // Abort: no further acks. The beat that just ended is still written.
            state_reg <= IDLE;
            ram_ack   <= 1'b0;
            busy      <= 1'b0;
            beat_reg  <= '0;
          end else if (beat_reg == LAST_BEAT) begin
            state_reg <= HOLD;
            ram_ack   <= 1'b0;
            busy      <= 1'b0;
            beat_reg  <= '0;
          end else begin
            beat_reg <= beat_reg + 1'b1;
            if (rnw_reg) begin
              ram_rdata <= mem[rd_addr];
            end
          end
        end

        HOLD: begin
          // A request left high from the finished burst must not start another.
          if (!ram_avalid) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_line_server.sv
// Bench for ram_line_server. Two instances are tested: one with LATENCY=2
// (index 0) and one with LATENCY=0 (index 1). Each transaction fills a
// per-cycle schedule of expected ack/busy/rdata values, taken from the line
// timing rules and a byte-array model of the memory. A single negedge process
// checks both DUTs against that schedule on every cycle.
module tb_ram_line_server;

  localparam int N = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic [11:0] addr_in  [2];
  logic        avalid   [2];
  logic        rnw_in   [2];
  logic [7:0]  wdata    [2];
  logic [7:0]  rdata    [2];
  logic        ack      [2];
  logic        busy     [2];
  logic [15:0] dbg_addr [2];
  logic [7:0]  dbg_rdata[2];

  always #5 clk = ~clk;

  ram_line_server #(.LATENCY(2)) u_dut_l2 (
    .ram_clk(clk), .rst(rst), .ram_addr(addr_in[0]), .ram_avalid(avalid[0]),
    .ram_rnw(rnw_in[0]), .ram_wdata(wdata[0]), .ram_rdata(rdata[0]),
    .ram_ack(ack[0]), .busy(busy[0]), .dbg_addr(dbg_addr[0]), .dbg_rdata(dbg_rdata[0])
  );

  ram_line_server #(.LATENCY(0)) u_dut_l0 (
    .ram_clk(clk), .rst(rst), .ram_addr(addr_in[1]), .ram_avalid(avalid[1]),
    .ram_rnw(rnw_in[1]), .ram_wdata(wdata[1]), .ram_rdata(rdata[1]),
    .ram_ack(ack[1]), .busy(busy[1]), .dbg_addr(dbg_addr[1]), .dbg_rdata(dbg_rdata[1])
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  // Expected schedule, indexed by the count of rising edges seen so far.
  bit         exp_ack [2][N];
  bit         exp_busy[2][N];
  bit         exp_rv  [2][N];
  logic [7:0] exp_rd  [2][N];

  // Memory model for each DUT. The index is {line, byte}.
  logic [7:0] mm [2][65536];

  logic [7:0] rd_first, rd_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // One compare process for both DUTs, run every cycle.
  always @(negedge clk) begin
    if (armed && cyc < N) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ack[%0d]@%0d", d, cyc), 32'(ack[d]), 32'(exp_ack[d][cyc]));
        chk($sformatf("busy[%0d]@%0d", d, cyc), 32'(busy[d]), 32'(exp_busy[d][cyc]));
        if (exp_rv[d][cyc])
          chk($sformatf("rdata[%0d]@%0d", d, cyc), 32'(rdata[d]), 32'(exp_rd[d][cyc]));
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic clear_from(input int d, input int from);
    for (int k = from; k < N; k++) begin
      exp_ack[d][k]  = 1'b0;
      exp_busy[d][k] = 1'b0;
      exp_rv[d][k]   = 1'b0;
    end
  endtask

  // Run one line transaction. Call it at a negedge with the DUT idle.
  // drop_beat and rst_beat are -1 when unused. hold_cyc keeps ram_avalid high
  // that many extra cycles after the burst ends. chg changes addr/rnw mid-burst.
  task automatic txn(input int d, input logic [11:0] line, input bit rnw,
                     input logic [7:0] wbase, input int drop_beat, input int rst_beat,
                     input int hold_cyc, input bit chg);
    int lat, a, e, idx;
    lat = (d == 0) ? 2 : 0;
    addr_in[d] = line;
    rnw_in[d]  = rnw;
    avalid[d]  = 1'b1;
    a = cyc + 1;
    for (int j = 0; j < lat; j++) exp_busy[d][a + j] = 1'b1;
    for (int b = 0; b < 16; b++) begin
      e   = a + lat + b;
      idx = int'(line) * 16 + b;
      exp_ack[d][e]  = 1'b1;
      exp_busy[d][e] = 1'b1;
      if (rnw) begin
        exp_rv[d][e] = 1'b1;
        exp_rd[d][e] = mm[d][idx];
      end
    end
    if (lat > 0) begin
      wait_cyc(a + lat - 1);
      chk("ack_low_before_first_beat", 32'(ack[d]), 32'd0);
    end
    for (int b = 0; b < 16; b++) begin
      wait_cyc(a + lat + b);
      idx = int'(line) * 16 + b;
      if (b == 0) chk("first_beat_ack", 32'(ack[d]), 32'd1);
      if (rnw && b == 0)  rd_first = rdata[d];
      if (rnw && b == 15) rd_last  = rdata[d];
      if (!rnw) begin
        wdata[d]   = wbase + 8'(b);
        mm[d][idx] = wdata[d];
      end
      if (chg && b == 3) begin
        addr_in[d] = line ^ 12'h0F0;
        rnw_in[d]  = ~rnw;
        wdata[d]   = 8'hEE;
      end
      if (b == rst_beat) begin
        #2 rst = 1'b0;
        avalid[d] = 1'b0;
        clear_from(0, a + lat + b + 1);
        clear_from(1, a + lat + b + 1);
        #1;
        chk("async_rst_ack", 32'(ack[d]), 32'd0);
        chk("async_rst_busy", 32'(busy[d]), 32'd0);
        chk("async_rst_rdata", 32'(rdata[d]), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        return;
      end
      if (b == drop_beat) begin
        avalid[d] = 1'b0;
        clear_from(d, a + lat + b + 1);
        wait_cyc(a + lat + b + 1);
        return;
      end
    end
    wait_cyc(a + lat + 16 + hold_cyc);
    avalid[d] = 1'b0;
    wait_cyc(cyc + 1);
  endtask

  task automatic lit(input int d, input logic [15:0] adr, input logic [7:0] want, input string nm);
    dbg_addr[d] = adr;
    #1;
    chk(nm, 32'(dbg_rdata[d]), 32'(want));
  endtask

  task automatic dbg_line(input int d, input logic [11:0] line, input string nm);
    for (int b = 0; b < 16; b++) begin
      dbg_addr[d] = {line, 4'(b)};
      #1;
      chk($sformatf("%s_b%0d", nm, b), 32'(dbg_rdata[d]), 32'(mm[d][int'(line) * 16 + b]));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr_in[d] = '0; avalid[d] = 1'b0; rnw_in[d] = 1'b1;
      wdata[d] = '0; dbg_addr[d] = '0;
    end
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(ack[d]), 32'd0);
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_rdata", 32'(rdata[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    armed = 1'b1;
    @(negedge clk);

    // LATENCY=2: preload line 0x3A5 with 0x00..0x0F, then read it back.
    txn(0, 12'h3A5, 1'b0, 8'h00, -1, -1, 0, 1'b0);
    lit(0, 16'h3A50, 8'h00, "pre_3a5_b0");
    lit(0, 16'h3A5A, 8'h0A, "pre_3a5_b10");
    @(negedge clk);
    txn(0, 12'h3A5, 1'b1, 8'h00, -1, -1, 0, 1'b0);
    chk("rd_3a5_first", 32'(rd_first), 32'h00);
    chk("rd_3a5_last", 32'(rd_last), 32'h0F);

    // Write line 0x012 between two preloaded neighbour lines.
    txn(0, 12'h011, 1'b0, 8'h20, -1, -1, 0, 1'b0);
    txn(0, 12'h013, 1'b0, 8'h40, -1, -1, 0, 1'b0);
    txn(0, 12'h012, 1'b0, 8'hF0, -1, -1, 0, 1'b0);
    lit(0, 16'h0120, 8'hF0, "wr_012_b0");
    lit(0, 16'h012F, 8'hFF, "wr_012_b15");
    lit(0, 16'h0110, 8'h20, "nb_011_b0");
    lit(0, 16'h013F, 8'h4F, "nb_013_b15");
    @(negedge clk);
    dbg_line(0, 12'h011, "line011");
    dbg_line(0, 12'h012, "line012");
    dbg_line(0, 12'h013, "line013");

    // ram_avalid held 5 cycles past the last beat, then a new request to 0x7FF.
    txn(0, 12'h7FF, 1'b0, 8'h50, -1, -1, 0, 1'b0);
    txn(0, 12'h3A5, 1'b1, 8'h00, -1, -1, 5, 1'b0);
    txn(0, 12'h7FF, 1'b1, 8'h00, -1, -1, 0, 1'b0);
    chk("rd_7ff_first", 32'(rd_first), 32'h50);
    chk("rd_7ff_last", 32'(rd_last), 32'h5F);

    // Write aborted after beat 5.
    txn(0, 12'h055, 1'b0, 8'h60, -1, -1, 0, 1'b0);
    txn(0, 12'h055, 1'b0, 8'hA0, 5, -1, 0, 1'b0);
    lit(0, 16'h0555, 8'hA5, "abort_b5_written");
    lit(0, 16'h0556, 8'h66, "abort_b6_kept");
    @(negedge clk);
    dbg_line(0, 12'h055, "line055");
    txn(0, 12'h055, 1'b1, 8'h00, -1, -1, 0, 1'b0);

    // Reset pulse during beat 9 of a read, then a normal read.
    txn(0, 12'h3A5, 1'b1, 8'h00, -1, 9, 0, 1'b0);
    txn(0, 12'h3A5, 1'b1, 8'h00, -1, -1, 0, 1'b0);
    chk("post_rst_first", 32'(rd_first), 32'h00);
    chk("post_rst_last", 32'(rd_last), 32'h0F);

    // LATENCY=0: preload, then read while ram_addr/ram_rnw change mid-burst.
    txn(1, 12'h100, 1'b0, 8'h30, -1, -1, 0, 1'b0);
    txn(1, 12'h100, 1'b1, 8'h00, -1, -1, 0, 1'b1);
    chk("l0_rd_first", 32'(rd_first), 32'h30);
    chk("l0_rd_last", 32'(rd_last), 32'h3F);
    lit(1, 16'h1005, 8'h35, "l0_line100_b5");
    @(negedge clk);
    dbg_line(1, 12'h100, "line100");

    repeat (3) @(negedge clk);
    chk("cycle_budget", 32'(cyc < N), 32'd1);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
